// File: rtl/tcp_tx_pkg.sv
// Shared constants for the SiTCP transmit channel multiplexer: header nibble,
// frame-engine state encoding and a ceil-log2 helper for sizing counters.
package tcp_tx_pkg;

    localparam logic [3:0] HDR_NIBBLE = 4'hA;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_HDR0 = 2'd1;
    localparam logic [1:0] ST_HDR1 = 2'd2;
    localparam logic [1:0] ST_DATA = 2'd3;

    // ceil(log2(value)); returns 0 for value <= 1
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int v = value - 1; v > 0; v = v >> 1) r++;
        return r;
    endfunction

endpackage

// File: rtl/tcp_tx_ch_mux_if.sv
// Channel-side and SiTCP-side signals of the transmit multiplexer.
interface tcp_tx_ch_mux_if #(
    parameter int N_CH = 4
);
    logic [N_CH-1:0]   CH_WR;
    logic [8*N_CH-1:0] CH_DATA;
    logic [N_CH-1:0]   CH_PFULL;
    logic [N_CH-1:0]   CH_OVF;
    logic              TCP_TX_FULL;
    logic              TCP_TX_WR;
    logic [7:0]        TCP_TX_DATA;
    logic              BUSY;

    modport master (
        output CH_WR, CH_DATA, TCP_TX_FULL,
        input  CH_PFULL, CH_OVF, TCP_TX_WR, TCP_TX_DATA, BUSY
    );

    modport slave (
        input  CH_WR, CH_DATA, TCP_TX_FULL,
        output CH_PFULL, CH_OVF, TCP_TX_WR, TCP_TX_DATA, BUSY
    );
endinterface

// File: rtl/tcp_tx_ch_fifo.sv
// Per-channel byte FIFO with show-ahead read, occupancy count, registered
// prog-full flag and sticky overflow flag.
module tcp_tx_ch_fifo
    import tcp_tx_pkg::*;
#(
    parameter int DEPTH    = 1024,
    parameter int PFULL_TH = DEPTH - 64,
    localparam int AW      = clog2(DEPTH),
    localparam int CW      = AW + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          wr_en,
    input  logic [7:0]    wr_data,
    input  logic          rd_en,
    output logic [7:0]    rd_data,
    output logic [CW-1:0] count,
    output logic          pfull,
    output logic          ovf
);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_wr;
    logic          do_rd;
    logic [CW-1:0] count_nxt;

    // a read frees a slot in the same cycle, so a full FIFO still takes a write
    assign do_rd   = rd_en && (count != '0);
    assign do_wr   = wr_en && ((count != CW'(DEPTH)) || do_rd);
    assign rd_data = mem[rd_ptr];

    always_comb begin
        // NOTE: default assignment first so every path drives count_nxt and no latch is inferred.
        count_nxt = count;
        if (do_wr && !do_rd)
            count_nxt = count + 1'b1;
        else if (!do_wr && do_rd)
            count_nxt = count - 1'b1;
    end

    // NOTE: storage has no reset; emptiness is tracked by the pointers/count, which keeps it RAM-inferable.
    always_ff @(posedge clk) begin
        if (do_wr)
            mem[wr_ptr] <= wr_data;
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            pfull  <= 1'b0;
            ovf    <= 1'b0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            pfull  <= 1'b0;
            ovf    <= 1'b0;
        end else begin
            if (do_wr)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_rd)
                rd_ptr <= rd_ptr + 1'b1;
            count <= count_nxt;
            pfull <= (32'(count_nxt) >= PFULL_TH);
            if (wr_en && !do_wr)
                ovf <= 1'b1;
        end
    end

endmodule

// File: rtl/tcp_tx_ch_mux.sv
// Multiplexes N_CH byte channels into framed bursts (2 header bytes + payload)
// for the SiTCP transmit port, with round-robin arbitration and idle flush.
module tcp_tx_ch_mux
    import tcp_tx_pkg::*;
#(
    parameter int N_CH      = 4,
    parameter int DEPTH     = 1024,
    parameter int FRAME_LEN = 64,
    parameter int PFULL_TH  = DEPTH - 64,
    parameter int TMO_CYC   = 200000
) (
    input  logic           CLK,
    input  logic           SYS_RSTn,
    input  logic           CLR,
    tcp_tx_ch_mux_if.slave bus
);

    localparam int CH_W  = (N_CH > 1) ? clog2(N_CH) : 1;
    localparam int CNT_W = clog2(DEPTH) + 1;
    localparam int LEN_W = clog2(FRAME_LEN + 1);
    localparam int TMO_W = clog2(TMO_CYC + 1);

    logic [1:0]       rst_sync;
    logic             rst_n;
    logic [1:0]       state;
    logic [CH_W-1:0]  cur_ch;
    logic [CH_W-1:0]  rr_ptr;
    logic [CH_W-1:0]  pick;
    logic [CH_W-1:0]  idx;
    logic             found;
    logic [LEN_W-1:0] frame_len;
    logic [LEN_W-1:0] byte_cnt;
    logic [TMO_W-1:0] flush_cnt;
    logic             flush;
    logic             tx_wr;
    logic [7:0]       tx_data;
    logic [N_CH-1:0]  len_ok;
    logic [N_CH-1:0]  nonempty;
    logic [N_CH-1:0]  elig;
    logic [N_CH-1:0]  rd_en;
    logic [N_CH-1:0]  pfull_v;
    logic [N_CH-1:0]  ovf_v;
    logic [CNT_W-1:0] occ [N_CH];
    logic [7:0]       rd_data [N_CH];

    // reset asserts asynchronously but releases only on a clock edge
    always_ff @(posedge CLK or negedge SYS_RSTn) begin
        if (!SYS_RSTn)
            rst_sync <= 2'b00;
        else
            rst_sync <= {rst_sync[0], 1'b1};
    end
    assign rst_n = rst_sync[1];

    for (genvar k = 0; k < N_CH; k++) begin : g_ch
        assign rd_en[k]    = (state == ST_DATA) && !bus.TCP_TX_FULL && (cur_ch == CH_W'(k));
        assign len_ok[k]   = (32'(occ[k]) >= FRAME_LEN);
        assign nonempty[k] = (occ[k] != '0);
        assign elig[k]     = len_ok[k] || (flush && nonempty[k]);

        tcp_tx_ch_fifo #(
            .DEPTH    (DEPTH),
            .PFULL_TH (PFULL_TH)
        ) u_fifo (
            .clk     (CLK),
            .rst_n   (rst_n),
            .clr     (CLR),
            .wr_en   (bus.CH_WR[k]),
            .wr_data (bus.CH_DATA[8*k +: 8]),
            .rd_en   (rd_en[k]),
            .rd_data (rd_data[k]),
            .count   (occ[k]),
            .pfull   (pfull_v[k]),
            .ovf     (ovf_v[k])
        );
    end

    assign flush = (32'(flush_cnt) >= TMO_CYC);

    // round-robin: first eligible channel at or after rr_ptr
    always_comb begin
        found = 1'b0;
        pick  = '0;
        idx   = '0;
        for (int i = 0; i < N_CH; i++) begin
            idx = CH_W'((int'(rr_ptr) + i) % N_CH);
            if (!found && elig[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            cur_ch    <= '0;
            rr_ptr    <= '0;
            frame_len <= '0;
            byte_cnt  <= '0;
            flush_cnt <= '0;
            tx_wr     <= 1'b0;
            tx_data   <= 8'h00;
        end else if (CLR) begin
            state     <= ST_IDLE;
            byte_cnt  <= '0;
            flush_cnt <= '0;
            tx_wr     <= 1'b0;
            tx_data   <= 8'h00;
        end else begin
            tx_wr <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (found) begin
                        state     <= ST_HDR0;
                        cur_ch    <= pick;
                        rr_ptr    <= CH_W'((int'(pick) + 1) % N_CH);
                        frame_len <= len_ok[pick] ? LEN_W'(FRAME_LEN) : LEN_W'(occ[pick]);
                        byte_cnt  <= '0;
                        flush_cnt <= '0;
                    end else if ((|nonempty) && !(|len_ok)) begin
                        if (!flush)
                            flush_cnt <= flush_cnt + 1'b1;
                    end else begin
                        flush_cnt <= '0;
                    end
                end
                ST_HDR0: if (!bus.TCP_TX_FULL) begin
                    tx_wr   <= 1'b1;
                    tx_data <= {HDR_NIBBLE, 4'(cur_ch)};
                    state   <= ST_HDR1;
                end
                ST_HDR1: if (!bus.TCP_TX_FULL) begin
                    tx_wr   <= 1'b1;
                    tx_data <= 8'(frame_len - 1'b1);
                    state   <= ST_DATA;
                end
                ST_DATA: if (!bus.TCP_TX_FULL) begin
                    tx_wr    <= 1'b1;
                    tx_data  <= rd_data[cur_ch];
                    byte_cnt <= byte_cnt + 1'b1;
                    if (byte_cnt == frame_len - 1'b1)
                        state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.TCP_TX_WR   = tx_wr;
    assign bus.TCP_TX_DATA = tx_data;
    assign bus.BUSY        = (state != ST_IDLE);
    assign bus.CH_PFULL    = pfull_v;
    assign bus.CH_OVF      = ovf_v;

endmodule

// File: tb/tb_tcp_tx_ch_mux.sv
// Randomized scoreboard bench for tcp_tx_ch_mux: per-channel byte queues model
// the FIFOs, frames are predicted by round-robin rules, a monitor checks every strobe.
module tb_tcp_tx_ch_mux;

    localparam int N_CH      = 4;
    localparam int DEPTH     = 128;
    localparam int FRAME_LEN = 64;
    localparam int PFULL_TH  = 100;
    localparam int TMO_CYC   = 100;

    typedef logic [7:0] byte_q_t[$];

    logic CLK      = 1'b0;
    logic SYS_RSTn = 1'b0;
    logic CLR      = 1'b0;

    tcp_tx_ch_mux_if #(.N_CH(N_CH)) bus ();

    tcp_tx_ch_mux #(
        .N_CH      (N_CH),
        .DEPTH     (DEPTH),
        .FRAME_LEN (FRAME_LEN),
        .PFULL_TH  (PFULL_TH),
        .TMO_CYC   (TMO_CYC)
    ) dut (
        .CLK      (CLK),
        .SYS_RSTn (SYS_RSTn),
        .CLR      (CLR),
        .bus      (bus)
    );

    always #5 CLK = ~CLK;

    int         checks = 0;
    int         errors = 0;
    int         out_cnt = 0;
    int         model_rr = 0;
    byte_q_t    mq [N_CH];
    logic [7:0] exp_q [$];
    logic [7:0] mon_exp;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: every strobe must match the next predicted byte.
    always @(negedge CLK) begin
        if (SYS_RSTn && bus.TCP_TX_WR === 1'b1) begin
            out_cnt++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_byte: got 0x%0h expected no strobe at %0t", bus.TCP_TX_DATA, $time);
            end else begin
                mon_exp = exp_q.pop_front();
                if (bus.TCP_TX_DATA !== mon_exp) begin
                    errors++;
                    $display("FAIL tx_byte #%0d: got 0x%0h expected 0x%0h", out_cnt, bus.TCP_TX_DATA, mon_exp);
                end
            end
        end
    end

    task automatic drive_cycle(input logic [N_CH-1:0] wr, input logic [8*N_CH-1:0] d);
        @(negedge CLK);
        bus.CH_WR   = wr;
        bus.CH_DATA = d;
        for (int k = 0; k < N_CH; k++)
            if (wr[k] && mq[k].size() < DEPTH)
                mq[k].push_back(d[8*k +: 8]);
    endtask

    task automatic rand_write(input logic [N_CH-1:0] wr);
        logic [8*N_CH-1:0] d;
        for (int k = 0; k < N_CH; k++)
            d[8*k +: 8] = 8'($urandom);
        drive_cycle(wr, d);
    endtask

    task automatic end_writes();
        @(negedge CLK);
        bus.CH_WR = '0;
    endtask

    task automatic emit_frame(input int k);
        int len;
        len = (mq[k].size() < FRAME_LEN) ? mq[k].size() : FRAME_LEN;
        exp_q.push_back({4'hA, 4'(k)});
        exp_q.push_back(8'(len - 1));
        for (int i = 0; i < len; i++)
            exp_q.push_back(mq[k].pop_front());
        model_rr = (k + 1) % N_CH;
    endtask

    // Predict frames from queue contents: full frames first, then flushes if allowed.
    task automatic plan_frames(input bit allow_flush);
        int sel;
        int k;
        forever begin
            sel = -1;
            for (int i = 0; i < N_CH; i++) begin
                k = (model_rr + i) % N_CH;
                if (sel < 0 && mq[k].size() >= FRAME_LEN) sel = k;
            end
            if (sel < 0 && allow_flush)
                for (int i = 0; i < N_CH; i++) begin
                    k = (model_rr + i) % N_CH;
                    if (sel < 0 && mq[k].size() > 0) sel = k;
                end
            if (sel < 0) break;
            emit_frame(sel);
        end
    endtask

    task automatic clear_model();
        exp_q.delete();
        for (int k = 0; k < N_CH; k++)
            mq[k].delete();
    endtask

    task automatic wait_out(input string name, input int target, input int budget);
        int n;
        n = 0;
        while (out_cnt < target && n < budget) begin
            @(negedge CLK);
            n++;
        end
        if (out_cnt < target) check(name, 32'(out_cnt), 32'(target));
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || bus.BUSY !== 1'b0) && n < budget) begin
            @(negedge CLK);
            n++;
        end
        check({name, "_pending"}, 32'(exp_q.size()), 32'd0);
        check({name, "_busy"}, {31'd0, bus.BUSY}, 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int lat;
        logic [8*N_CH-1:0] d;

        bus.CH_WR       = '0;
        bus.CH_DATA     = '0;
        bus.TCP_TX_FULL = 1'b0;
        repeat (3) @(negedge CLK);
        check("rst_tx_wr",   {31'd0, bus.TCP_TX_WR}, 32'd0);
        check("rst_tx_data", {24'd0, bus.TCP_TX_DATA}, 32'd0);
        check("rst_ovf",     {28'd0, bus.CH_OVF}, 32'd0);
        check("rst_pfull",   {28'd0, bus.CH_PFULL}, 32'd0);
        check("rst_busy",    {31'd0, bus.BUSY}, 32'd0);
        SYS_RSTn = 1'b1;
        repeat (5) @(negedge CLK);

        // 64 counting bytes into ch2 -> A2 3F 00..3F
        base = out_cnt;
        for (int i = 0; i < 64; i++) begin
            d = '0;
            d[8*2 +: 8] = 8'(i);
            drive_cycle(4'b0100, d);
        end
        plan_frames(1'b0);
        end_writes();
        wait_drain("single_frame", 400);
        check("single_frame_strobes", 32'(out_cnt - base), 32'd66);

        // ch0/ch1 with 128 bytes each, plus a 10-cycle back-pressure hold
        bus.TCP_TX_FULL = 1'b1;
        for (int i = 0; i < 128; i++) rand_write(4'b0011);
        plan_frames(1'b0);
        end_writes();
        base = out_cnt;
        bus.TCP_TX_FULL = 1'b0;
        wait_out("hold_reach_payload", base + 20, 400);
        bus.TCP_TX_FULL = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge CLK);
            check("hold_no_strobe", {31'd0, bus.TCP_TX_WR}, 32'd0);
        end
        bus.TCP_TX_FULL = 1'b0;
        wait_drain("rr_frames", 1500);
        check("rr_frames_strobes", 32'(out_cnt - base), 32'd264);

        // 5 bytes into ch3 are flushed after the idle timeout
        for (int i = 0; i < 5; i++) rand_write(4'b1000);
        plan_frames(1'b1);
        end_writes();
        base = out_cnt;
        lat = 0;
        while (out_cnt == base && lat < 400) begin
            @(negedge CLK);
            lat++;
        end
        check("flush_latency_window", {31'd0, (lat >= 94 && lat <= 108)}, 32'd1);
        wait_drain("flush_frame", 200);
        check("flush_frame_strobes", 32'(out_cnt - base), 32'd7);

        // overflow ch1 while the output is blocked; prog-full edge and sticky overflow
        bus.TCP_TX_FULL = 1'b1;
        for (int n = 1; n <= DEPTH + 12; n++) begin
            rand_write(4'b0010);
            @(posedge CLK);
            #1;
            if (n == PFULL_TH - 1 || n == PFULL_TH)
                check("pfull_edge", {28'd0, bus.CH_PFULL}, (n >= PFULL_TH) ? 32'h2 : 32'h0);
            if (n == DEPTH || n == DEPTH + 1)
                check("ovf_edge", {28'd0, bus.CH_OVF}, (n > DEPTH) ? 32'h2 : 32'h0);
        end
        plan_frames(1'b0);
        end_writes();
        base = out_cnt;
        for (int i = 0; i < 600 && exp_q.size() != 0; i++) begin
            @(negedge CLK);
            bus.TCP_TX_FULL = ($urandom_range(0, 3) == 0);
        end
        bus.TCP_TX_FULL = 1'b0;
        wait_drain("ovf_frames", 400);
        check("ovf_frames_strobes", 32'(out_cnt - base), 32'd132);
        check("ovf_sticky", {28'd0, bus.CH_OVF}, 32'h2);

        // CLR at payload byte 10 aborts the frame and empties every channel
        for (int i = 0; i < 64; i++) rand_write((i < 10) ? 4'b0101 : 4'b0001);
        plan_frames(1'b0);
        end_writes();
        base = out_cnt;
        wait_out("clr_reach_payload", base + 12, 400);
        CLR = 1'b1;
        @(negedge CLK);
        CLR = 1'b0;
        check("clr_tx_wr", {31'd0, bus.TCP_TX_WR}, 32'd0);
        check("clr_busy",  {31'd0, bus.BUSY}, 32'd0);
        check("clr_ovf",   {28'd0, bus.CH_OVF}, 32'd0);
        check("clr_pfull", {28'd0, bus.CH_PFULL}, 32'd0);
        clear_model();
        base = out_cnt;
        repeat (150) @(negedge CLK);
        check("clr_fifos_empty", 32'(out_cnt - base), 32'd0);

        // reset mid-frame, then confirm arbitration restarts at channel 0
        for (int i = 0; i < 64; i++) rand_write(4'b0010);
        plan_frames(1'b0);
        end_writes();
        base = out_cnt;
        wait_out("rst_reach_payload", base + 7, 400);
        SYS_RSTn = 1'b0;
        #1;
        check("rst_mid_tx_wr", {31'd0, bus.TCP_TX_WR}, 32'd0);
        check("rst_mid_busy",  {31'd0, bus.BUSY}, 32'd0);
        @(negedge CLK);
        check("rst_mid_tx_wr_next", {31'd0, bus.TCP_TX_WR}, 32'd0);
        check("rst_mid_busy_next",  {31'd0, bus.BUSY}, 32'd0);
        clear_model();
        model_rr = 0;
        SYS_RSTn = 1'b1;
        base = out_cnt;
        repeat (150) @(negedge CLK);
        check("rst_fifos_empty", 32'(out_cnt - base), 32'd0);

        bus.TCP_TX_FULL = 1'b1;
        for (int i = 0; i < 64; i++) rand_write(4'b1010);
        plan_frames(1'b0);
        end_writes();
        base = out_cnt;
        bus.TCP_TX_FULL = 1'b0;
        wait_drain("post_rst_frames", 600);
        check("post_rst_frames_strobes", 32'(out_cnt - base), 32'd132);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/tcp_tx_ch_mux.md
TCP_TX_CH_MUX -- requirements
Module: tcp_tx_ch_mux

Interface
REQ-001 Parameter N_CH, default 4, number of input byte channels (1..16).
REQ-002 Parameter DEPTH, default 1024, bytes per channel FIFO (power of 2, 16..4096).
REQ-003 Parameter FRAME_LEN, default 64, maximum payload bytes per frame (1..256).
REQ-004 Parameter PFULL_TH, default DEPTH-64, channel prog-full threshold in bytes.
REQ-005 Parameter TMO_CYC, default 200000, flush timeout in CLK cycles (1 ms at 200 MHz).
REQ-006 CLK  in  1  system clock (CLK_200M domain).
REQ-007 SYS_RSTn  in  1  one clock; reset is asynchronous and active-low.
REQ-008 CLR  in  1  synchronous clear; driven by the integrator as ~TCP_OPEN_ACK | SOFT_RESET.
REQ-009 CH_WR  in  N_CH  per-channel byte write strobe.
REQ-010 CH_DATA  in  8*N_CH  per-channel write byte; channel k occupies bits [8k+7:8k].
REQ-011 CH_PFULL  out  N_CH  channel occupancy >= PFULL_TH.
REQ-012 CH_OVF  out  N_CH  sticky flag: a write was dropped because the channel FIFO was full.
REQ-013 TCP_TX_FULL  in  1  SiTCP almost-full flag.
REQ-014 TCP_TX_WR  out  1  byte write strobe to SiTCP.
REQ-015 TCP_TX_DATA  out  8  byte to SiTCP.
REQ-016 BUSY  out  1  high when the frame engine is outside IDLE.

Function
REQ-017 Each channel SHALL buffer bytes in its own FIFO; a write to a full FIFO is dropped and sets CH_OVF[k]; a simultaneous read and write on a full FIFO is accepted.
REQ-018 Channel k is eligible when its occupancy >= FRAME_LEN, or when the flush condition holds and its occupancy > 0.
REQ-019 A flush counter SHALL count cycles in IDLE while at least one FIFO is non-empty and none holds >= FRAME_LEN; flush holds when the count reaches TMO_CYC; the counter clears on leaving IDLE and on CLR.
REQ-020 Arbitration SHALL be round-robin, starting the search at the channel after the last one served; after reset the search starts at channel 0.
REQ-021 The state machine SHALL be: IDLE -> HDR0 on any eligible channel (latching channel and L = min(occupancy, FRAME_LEN)); HDR0 -> HDR1 -> DATA; DATA -> IDLE after L payload bytes.
REQ-022 Header byte 0 = {4'hA, ch[3:0]}; header byte 1 = L-1 (8 bits); payload = L bytes from the FIFO in write order.
REQ-023 Outputs SHALL be registered; a byte is issued, and the state or count advances, only in a cycle where TCP_TX_FULL is sampled low; otherwise TCP_TX_WR is 0 next cycle and the state holds.
REQ-024 Bytes SHALL never be issued while in IDLE; back-to-back frames SHALL have at least one idle cycle between them.
REQ-025 CH_PFULL and occupancy SHALL reflect writes with one-cycle latency.
REQ-026 CLR SHALL empty all FIFOs, clear CH_OVF, return to IDLE and abort any frame in progress (a truncated frame is acceptable because the connection is closing); TCP_TX_WR is 0 the cycle after CLR.

Reset
REQ-027 When SYS_RSTn is low: FIFOs empty, state IDLE, round-robin pointer 0, flush counter 0, TCP_TX_WR=0, TCP_TX_DATA=0, CH_OVF=0, CH_PFULL=0, BUSY=0.
REQ-028 Deassertion of SYS_RSTn SHALL be synchronised inside the block before it reaches the sequential logic.

Structure
REQ-029 Header nibble 4'hA, state encoding and a clog2 helper SHALL live in the shared package tcp_tx_pkg.
REQ-030 The per-channel FIFO SHALL be one sub-module, tcp_tx_ch_fifo (inferred BRAM/LUTRAM, occupancy count output), instantiated N_CH times via generate.

Verification
REQ-031 N_CH=4, FRAME_LEN=64: write 64 bytes 0x00..0x3F into ch2, TCP_TX_FULL=0 -> stream A2 3F 00..3F; 66 strobes total, then BUSY=0.
REQ-032 Ch0 and ch1 each hold 128 bytes -> frame order ch0, ch1, ch0, ch1; every header byte 1 = 0x3F.
REQ-033 TMO_CYC=100: write 5 bytes to ch3 -> after 100 idle cycles, output A3 04 followed by the 5 bytes.
REQ-034 Hold TCP_TX_FULL=1 for 10 cycles mid-payload -> no strobes during the hold; the stream resumes with no byte lost or duplicated.
REQ-035 DEPTH=16: 20 writes to ch1 with no reads -> CH_OVF[1]=1, 16 bytes retained, CH_PFULL[1] asserts at the PFULL_TH occupancy.
REQ-036 Assert CLR at payload byte 10, then assert SYS_RSTn low mid-frame -> TCP_TX_WR=0 and BUSY=0 on the following cycle; all occupancies read 0.
